// File: rtl/ads1118_pkg.sv
// Shared ADS1118 SPI definitions: frame lengths, config NOP check and FSM state encoding.
package ads1118_pkg;

  localparam logic [1:0] CFG_NOP_VALID = 2'b01;
  localparam logic [5:0] FRAME16       = 6'd16;
  localparam logic [5:0] FRAME32       = 6'd32;
  localparam logic [5:0] BCNT_MAX      = 6'd33;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_HI = 2'd2
  } state_t;

  // A config word is only written when its NOP field says "valid data".
  function automatic logic cfg_accept(input logic [15:0] word);
    return (word[2:1] == CFG_NOP_VALID);
  endfunction

endpackage

// File: rtl/ads1118_spi_responder_if.sv
// SPI pin bundle between the ADS1118 master and this responder.
interface ads1118_spi_responder_if;
  logic SCLK;
  logic CS;
  logic MOSI;
  logic MISO;
  logic MISO_OE;

  modport master (output SCLK, CS, MOSI, input MISO, MISO_OE);
  modport slave  (input SCLK, CS, MOSI, output MISO, MISO_OE);
endinterface

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin, followed by a registered edge detector.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK_50M,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  // Reset to 0 so a CS already high at reset release only yields an ignored rise.
  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev   <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev   <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev;
    end
  end

  assign level = prev;

endmodule

// File: rtl/ads1118_spi_responder.sv
// ADS1118 serial-interface emulator: returns injected conversion codes on MISO and
// captures config words from MOSI, with all SPI pins sampled in the CLK_50M domain.
module ads1118_spi_responder
  import ads1118_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] CFG_RESET   = 16'h058B,
  parameter bit          FRAME32_EN  = 1'b1
) (
  input  logic                           CLK_50M,
  input  logic                           rst_n,
  input  logic [15:0]                    sample_data,
  input  logic                           sample_valid,
  ads1118_spi_responder_if.slave         spi,
  output logic [15:0]                    cfg_out,
  output logic                           cfg_valid,
  output logic                           frame_err,
  output logic                           busy
);

  logic   sclk_rise, sclk_fall, sclk_lvl;
  logic   cs_rise, cs_fall, cs_lvl;
  logic   mosi_lvl, mosi_rise, mosi_fall;

  state_t      state;
  logic [5:0]  bcnt, bcnt_n;
  logic [15:0] tx_sh, rx_sh, rx_n, cap, cap_n, hold, load_word;
  logic        new_flag, miso_r, oe_r, next_bit, frame_ok;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .CLK_50M(CLK_50M), .rst_n(rst_n), .din(spi.SCLK),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .CLK_50M(CLK_50M), .rst_n(rst_n), .din(spi.CS),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .CLK_50M(CLK_50M), .rst_n(rst_n), .din(spi.MOSI),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

  // Synchronizer outputs with no consumer here; new_flag is the DRDY view kept for probing.
  logic unused_ok;
  assign unused_ok = &{1'b0, sclk_lvl, mosi_rise, mosi_fall, new_flag};

  // A fall coinciding with cs_rise is folded in before the frame is judged.
  always_comb begin
    bcnt_n    = bcnt;
    rx_n      = rx_sh;
    cap_n     = cap;
    next_bit  = 1'b0;
    load_word = sample_valid ? sample_data : hold;
    if (sclk_fall) begin
      rx_n = {rx_sh[14:0], mosi_lvl};
      if (bcnt != BCNT_MAX) bcnt_n = bcnt + 6'd1;
      if (bcnt_n == FRAME16) cap_n = rx_n;
    end
    if (bcnt < FRAME16)
      next_bit = tx_sh[4'(FRAME16 - 6'd1 - bcnt)];
    else if (FRAME32_EN && (bcnt < FRAME32))
      next_bit = cfg_out[4'(FRAME32 - 6'd1 - bcnt)];
    frame_ok = (bcnt_n == FRAME16) || (FRAME32_EN && (bcnt_n == FRAME32));
  end

  always_ff @(posedge CLK_50M or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_HI;
      bcnt      <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      cap       <= '0;
      hold      <= '0;
      new_flag  <= 1'b0;
      miso_r    <= 1'b1;
      oe_r      <= 1'b0;
      cfg_out   <= CFG_RESET;
      cfg_valid <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cfg_valid <= 1'b0;
      frame_err <= 1'b0;
      if (sample_valid) begin
        hold     <= sample_data;
        new_flag <= 1'b1;
      end
      case (state)
        WAIT_HI: begin
          miso_r <= 1'b1;
          oe_r   <= 1'b0;
          if (cs_lvl) state <= IDLE;
        end
        IDLE: begin
          miso_r <= 1'b1;
          oe_r   <= 1'b0;
          // MSB goes out immediately, before the first SCLK rise.
          if (cs_fall) begin
            tx_sh    <= load_word;
            new_flag <= 1'b0;
            bcnt     <= '0;
            miso_r   <= load_word[15];
            oe_r     <= 1'b1;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcnt  <= bcnt_n;
          rx_sh <= rx_n;
          cap   <= cap_n;
          if (sclk_rise && (bcnt != 6'd0)) miso_r <= next_bit;
          if (cs_rise) begin
            state  <= IDLE;
            busy   <= 1'b0;
            oe_r   <= 1'b0;
            miso_r <= 1'b1;
            if (frame_ok) begin
              if (cfg_accept(cap_n)) begin
                cfg_out   <= cap_n;
                cfg_valid <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= WAIT_HI;
      endcase
    end
  end

  assign spi.MISO    = miso_r;
  assign spi.MISO_OE = oe_r;

endmodule
